ex_mdu: RTL and testbench

Multiply/divide unit for the EX stage of the five-stage pipeline. It takes the forwarded register operands and an MDU opcode latched by the ID/EX pipeline register, and performs MIPS-style multiply/divide with fixed multi-cycle latency. It owns the architectural HI/LO registers and exposes a busy flag that the hazard unit uses to stall MDU-dependent instructions held in ID.

---
 rtl/ex_mdu_pkg.sv | 31 +++
 rtl/mdu_calc.sv | 53 +++++
 rtl/ex_mdu.sv | 95 +++++++++
 tb/tb_ex_mdu.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared pipeline definitions for the EX-stage multiply/divide unit:
// MDU opcodes (also used by the ID decoder and hazard unit), default latencies, FSM encoding.
package ex_mdu_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;
  } mdu_res_t;

  function automatic logic is_long_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: op/A/B -> {hi, lo, div_zero}.
// The divisor is forced to 1 on B==0 so the divider never sees zero; the caller discards that result.
module mdu_calc
  import ex_mdu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output mdu_res_t    res_o
);

  logic signed [63:0] sa, sb, sd, prod_s;
  logic        [63:0] ua, ub, ud, prod_u;
  logic        [31:0] q_s, r_s, q_u, r_u;
  logic               b_zero;

  always_comb begin
    b_zero = (b_i == 32'd0);
    sa     = {{32{a_i[31]}}, a_i};
    sb     = {{32{b_i[31]}}, b_i};
    ua     = {32'd0, a_i};
    ub     = {32'd0, b_i};
    sd     = b_zero ? 64'sd1 : sb;
    ud     = b_zero ? 64'd1  : ub;
    prod_s = sa * sb;
    prod_u = ua * ub;
    // 64-bit signed division makes 0x80000000 / -1 land on LO=0x80000000, HI=0 naturally.
    q_s    = 32'(sa / sd);
    r_s    = 32'(sa % sd);
    q_u    = 32'(ua / ud);
    r_u    = 32'(ua % ud);
  end

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_MULT:  {res_o.hi, res_o.lo} = prod_s;
      OP_MULTU: {res_o.hi, res_o.lo} = prod_u;
      OP_DIV: begin
        res_o.hi       = r_s;
        res_o.lo       = q_s;
        res_o.div_zero = b_zero;
      end
      OP_DIVU: begin
        res_o.hi       = r_u;
        res_o.lo       = q_u;
        res_o.div_zero = b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: owns HI/LO, runs MULT/DIV with fixed latency and
// exposes a registered busy flag for the hazard unit.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  mdu_res_t    calc;

  mdu_calc u_calc (
    .op_i  (op),
    .a_i   (A),
    .b_i   (B),
    .res_o (calc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_long_op(op)) begin
            res_d   = {calc.hi, calc.lo};
            dz_d    = calc.div_zero;
            cnt_d   = (op == OP_MULT || op == OP_MULTU) ? MULT_CNT : DIV_CNT;
            state_d = S_RUN;
          end else if (op == OP_MTHI) begin
            hi_d = A;
          end else if (op == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      S_RUN: begin
        // Any start seen here is dropped; HI/LO only move at completion.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          if (!dz_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      res_q   <= 64'd0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign busy = (state_q == S_RUN);

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: stimulus pushes expected HI/LO at a due cycle plus
// expected busy lengths; a negedge monitor pops and compares.
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] A, B, HI, LO;
  logic        busy;

  ex_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .HI(HI), .LO(LO), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          len_q[$];
  int          cyc = 0;
  int          total = 0, bad = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  exp_t e;
  int   w;
  logic busy_prev = 1'b0;
  int   blen = 0;
  always @(negedge clk) begin
    if (start === 1'b1 && busy === 1'b1 && is_long_op(op)) begin
      total++; bad++;
      $display("FAIL protocol: long op start while busy at cycle %0d", cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      total++;
      if (HI !== e.hi || LO !== e.lo || busy !== 1'b0) begin
        bad++;
        $display("FAIL %s: got HI=%h LO=%h busy=%b, want HI=%h LO=%h busy=0",
                 e.name, HI, LO, busy, e.hi, e.lo);
      end
    end
    if (busy === 1'b1) blen++;
    else begin
      if (busy_prev && len_q.size() > 0) begin
        w = len_q.pop_front();
        total++;
        if (blen != w) begin
          bad++;
          $display("FAIL busy_len: got %0d, want %0d", blen, w);
        end
      end
      blen = 0;
    end
    busy_prev = busy;
  end

  // reference model: architectural effect of one accepted instruction
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string nm);
    longint          p;
    longint unsigned pu;
    int              n;
    n = 0;
    case (o)
      OP_MULT:  begin p  = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p;  n = MC; end
      OP_MULTU: begin pu = {32'd0, a} * {32'd0, b};                      {m_hi, m_lo} = pu; n = MC; end
      OP_DIV: begin
        n = DC;
        if (b == 0) ;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = 32'h8000_0000; m_hi = 0; end
        else begin m_lo = int'(a) / int'(b); m_hi = int'(a) % int'(b); end
      end
      OP_DIVU: begin
        n = DC;
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
    exp_q.push_back('{cyc + 1 + (n == 0 ? 0 : n), m_hi, m_lo, nm});
    if (n != 0) len_q.push_back(n);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (busy === 1'b1) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, want 0", busy, n);
      $fatal(1, "bench stopped");
    end
  endtask

  // called at posedge+#1; start is sampled on the next edge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string nm);
    wait_idle();
    start = 1'b1; op = o; A = a; B = b;
    model(o, a, b, nm);
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || busy === 1'b1) && n < 200) begin @(posedge clk); #1; n++; end
    if (exp_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d checks pending, want 0", exp_q.size());
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; op = OP_NONE; A = 0; B = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.push_back('{cyc, 32'd0, 32'd0, "reset"});

    issue(OP_MULT,  32'hFFFF_FFFE, 32'd3, "mult_signed");
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2, "div_signed");
    issue(OP_DIV,   32'd5, 32'd0, "div_by_zero");
    issue(OP_DIVU,  32'd5, 32'd0, "divu_by_zero");
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    issue(OP_MTHI,  32'h1234, 32'd0, "mthi");
    issue(OP_MTLO,  32'h5678, 32'd0, "mtlo");
    issue(OP_MULT,  32'd2, 32'd3, "mult_mtlo_ignored");
    @(posedge clk); #1;
    start = 1'b1; op = OP_MTLO; A = 32'hDEAD;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    issue(OP_MULT,  32'd2, 32'd3, "b2b_mult");
    issue(OP_DIVU,  32'd9, 32'd4, "b2b_divu");
    issue(OP_NONE,  32'hAAAA, 32'd1, "op_none");
    issue(3'd7,     32'hBBBB, 32'd1, "op_reserved");

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), "random");
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();

    // reset three cycles into a DIVU
    issue(OP_DIVU, 32'd100, 32'd7, "divu_aborted");
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    exp_q.delete();
    len_q.delete();
    m_hi = 0; m_lo = 0;
    exp_q.push_back('{cyc + 1, 32'd0, 32'd0, "reset_mid_div"});
    exp_q.push_back('{cyc + DC + 3, 32'd0, 32'd0, "no_update_after_reset"});
    @(posedge clk); #1;
    reset = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
